// File: rtl/lut_neuron_pkg.sv
// rtl/lut_neuron_pkg.sv - shared sizes, FSM state and response type for the LUT neuron block
package lut_neuron_pkg;

    localparam int IN_BITS     = 8;
    localparam int OUT_BITS    = 2;
    localparam int NUM_NEURONS = 4;
    localparam int NID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int TABLE_DEPTH = 2 ** IN_BITS;
    localparam int RAM_AW      = NID_W + IN_BITS;

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    typedef struct packed {
        logic [OUT_BITS-1:0] data;
        logic                err;
    } resp_t;

    function automatic logic nid_ok(input logic [NID_W-1:0] nid);
        return ({1'b0, nid} < (NID_W + 1)'(NUM_NEURONS));
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - table storage for all neurons, one write port and one registered read port
module lut_neuron_ram
    import lut_neuron_pkg::*;
(
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [RAM_AW-1:0]   i_wr_addr,
    input  logic [OUT_BITS-1:0] i_wr_data,
    input  logic                i_rd_en,
    input  logic [RAM_AW-1:0]   i_rd_addr,
    output logic [OUT_BITS-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** RAM_AW;

    (* ram_style = "distributed" *) logic [OUT_BITS-1:0] r_mem [DEPTH];
    logic [OUT_BITS-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Read register only moves on a lookup, so a held response survives later loads.
    always_ff @(posedge clk) begin
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lut_neuron_cfg_ctrl.sv
// rtl/lut_neuron_cfg_ctrl.sv - load/lookup arbitration, table-valid tracking and response register
module lut_neuron_cfg_ctrl
    import lut_neuron_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [NID_W-1:0]    cfg_neuron,
    input  logic                cfg_valid,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_ready,
    output logic                cfg_busy,
    input  logic                req_valid,
    input  logic [NID_W-1:0]    req_neuron,
    input  logic [IN_BITS-1:0]  req_code,
    output logic                req_ready,
    output logic                resp_valid,
    output logic [OUT_BITS-1:0] resp_data,
    output logic                resp_err,
    input  logic                resp_ready
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [NID_W-1:0]       r_nid;
    logic [IN_BITS-1:0]     r_addr;
    logic [NUM_NEURONS-1:0] r_loaded;
    logic                   r_resp_valid;
    logic                   r_resp_err;

    logic                   w_cfg_accept;
    logic                   w_wr_en;
    logic                   w_last;
    logic                   w_req_fire;
    logic                   w_req_ok;
    logic [OUT_BITS-1:0]    w_rd_data;
    resp_t                  w_resp;

    assign w_cfg_accept = (r_state == IDLE) && cfg_start && nid_ok(cfg_neuron);
    assign w_wr_en      = (r_state == LOAD) && cfg_valid;
    assign w_last       = w_wr_en && (&r_addr);
    assign w_req_fire   = req_valid && req_ready;
    assign w_req_ok     = nid_ok(req_neuron) && r_loaded[req_neuron];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cfg_accept) w_next_state = LOAD;
            LOAD:    if (w_last)       w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // A start request always beats a lookup in the same cycle.
    always_comb begin
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        req_ready = 1'b0;
        if (r_state == LOAD) begin
            cfg_ready = 1'b1;
            cfg_busy  = 1'b1;
        end else begin
            req_ready = !rst && !cfg_start && (!r_resp_valid || resp_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nid        <= '0;
            r_addr       <= '0;
            r_loaded     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_cfg_accept) begin
                r_nid                <= cfg_neuron;
                r_addr               <= '0;
                r_loaded[cfg_neuron] <= 1'b0;
            end
            if (w_wr_en) begin
                r_addr <= r_addr + 1'b1;
                if (w_last) r_loaded[r_nid] <= 1'b1;
            end
            if (w_req_fire) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= !w_req_ok;
            end else if (resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    lut_neuron_ram u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({r_nid, r_addr}),
        .i_wr_data (cfg_data),
        .i_rd_en   (w_req_fire),
        .i_rd_addr ({req_neuron, req_code}),
        .o_rd_data (w_rd_data)
    );

    // RAM output is unreset, so the data is masked unless a good result is held.
    assign w_resp.data = (r_resp_valid && !r_resp_err) ? w_rd_data : '0;
    assign w_resp.err  = r_resp_err;

    assign resp_valid = r_resp_valid;
    assign resp_data  = w_resp.data;
    assign resp_err   = w_resp.err;

endmodule

// File: tb/tb_lut_neuron_cfg_ctrl.sv
// tb/tb_lut_neuron_cfg_ctrl.sv - randomized bench for lut_neuron_cfg_ctrl against a table model
module tb_lut_neuron_cfg_ctrl;

    localparam int NN    = 4;
    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start;
    logic [1:0] cfg_neuron;
    logic       cfg_valid;
    logic [1:0] cfg_data;
    logic       cfg_ready;
    logic       cfg_busy;
    logic       req_valid;
    logic [1:0] req_neuron;
    logic [7:0] req_code;
    logic       req_ready;
    logic       resp_valid;
    logic [1:0] resp_data;
    logic       resp_err;
    logic       resp_ready;

    int checks   = 0;
    int failures = 0;
    int model_tab [NN][DEPTH];
    bit model_loaded [NN];

    always #5 clk = ~clk;

    lut_neuron_cfg_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_neuron (cfg_neuron),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .cfg_busy   (cfg_busy),
        .req_valid  (req_valid),
        .req_neuron (req_neuron),
        .req_code   (req_code),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_err(input int n);
        return (n < NN && model_loaded[n]) ? 0 : 1;
    endfunction

    function automatic int exp_data(input int n, input int c);
        return exp_err(n) ? 0 : model_tab[n][c];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NN; i++) model_loaded[i] = 1'b0;
    endtask

    task automatic do_load(input int n, input bit toggle, input bit rnd, input bit hold_req, input int abort_at);
        int idx, cyc, busy, bad_rdy;
        logic [1:0] d;
        bit v;
        @(negedge clk);
        cfg_start  = 1'b1;
        cfg_neuron = 2'(n);
        if (hold_req) begin
            #1;
            check("start_wins_req_ready", req_ready, 0);
        end
        @(negedge clk);
        cfg_start = 1'b0;
        model_loaded[n] = 1'b0;
        idx = 0; cyc = 0; busy = 0; bad_rdy = 0;
        while (idx < DEPTH && idx < abort_at && cyc < 2000) begin
            if (cfg_busy) busy++;
            if (req_ready) bad_rdy++;
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            d = rnd ? 2'($urandom) : 2'(idx);
            cfg_valid = v;
            cfg_data  = d;
            if (v && cfg_ready) begin
                model_tab[n][idx] = d;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        cfg_valid = 1'b0;
        if (abort_at >= DEPTH) begin
            check("load_busy_cycles", busy, toggle ? 511 : 256);
            check("load_done_busy", cfg_busy, 0);
            check("load_no_req_accept", bad_rdy, 0);
            model_loaded[n] = 1'b1;
        end
    endtask

    task automatic do_req(input int n, input int code, input string tag);
        int w;
        @(negedge clk);
        req_valid  = 1'b1;
        req_neuron = 2'(n);
        req_code   = 8'(code);
        #1;
        w = 0;
        while (!req_ready && w < 600) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, "_accept_bound"}, w < 600, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_valid"}, resp_valid, 1);
        check({tag, "_data"}, resp_data, exp_data(n, code));
        check({tag, "_err"}, resp_err, exp_err(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int c0, held;
        int qn [4];
        int qc [4];
        rst = 1'b1; cfg_start = 1'b0; cfg_neuron = '0; cfg_valid = 1'b0; cfg_data = '0;
        req_valid = 1'b0; req_neuron = '0; req_code = '0; resp_ready = 1'b1;
        do_reset();

        do_req(0, 8'h00, "unloaded_n0");

        do_load(1, 1'b0, 1'b0, 1'b0, 256);
        do_req(1, 8'hA7, "n1_a7");
        check("n1_a7_const", resp_data, 2'b11);

        do_load(1, 1'b1, 1'b0, 1'b0, 256);
        do_req(1, 8'hFF, "n1_ff_toggle");

        @(negedge clk);
        req_valid  = 1'b1;
        req_neuron = 2'd1;
        req_code   = 8'($urandom);
        do_load(2, 1'b0, 1'b1, 1'b1, 256);
        #1;
        check("after_load_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("stalled_req_valid", resp_valid, 1);
        check("stalled_req_data", resp_data, exp_data(1, req_code));
        check("stalled_req_err", resp_err, 0);

        @(negedge clk);
        c0 = $urandom_range(0, 255);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_neuron = 2'd2;
        req_code   = 8'(c0);
        @(negedge clk);
        req_code = 8'($urandom);
        check("bp_valid", resp_valid, 1);
        check("bp_data", resp_data, exp_data(2, c0));
        held = exp_data(2, c0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 0);
            check("bp_hold_data", resp_data, held);
        end
        for (int k = 0; k < 4; k++) begin
            qn[k] = $urandom_range(0, 3);
            qc[k] = $urandom_range(0, 255);
        end
        resp_ready = 1'b1;
        req_neuron = 2'(qn[0]);
        req_code   = 8'(qc[0]);
        #1;
        check("b2b_req_ready", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_valid", resp_valid, 1);
            check("b2b_data", resp_data, exp_data(qn[k], qc[k]));
            check("b2b_err", resp_err, exp_err(qn[k]));
            if (k < 3) begin
                req_neuron = 2'(qn[k+1]);
                req_code   = 8'(qc[k+1]);
                #1;
                check("b2b_req_ready", req_ready, 1);
            end else begin
                req_valid = 1'b0;
            end
        end

        do_load(3, 1'b0, 1'b1, 1'b0, 100);
        do_reset();
        do_req(3, $urandom_range(0, 255), "after_rst_n3");
        do_req(1, $urandom_range(0, 255), "after_rst_n1");

        for (int r = 0; r < 3; r++) begin
            do_load($urandom_range(0, 3), 1'($urandom), 1'b1, 1'b0, 256);
        end
        for (int r = 0; r < 40; r++) begin
            do_req($urandom_range(0, 3), $urandom_range(0, 255), "rand_lookup");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_neuron_cfg_ctrl.md
Name: lut_neuron_cfg_ctrl

Overview:
Runtime-programmable replacement for the fixed LogicNets neuron ROMs. It holds NUM_NEURONS truth tables, each 2^IN_BITS entries of OUT_BITS, in distributed RAM. A configuration port streams a table into one neuron. A valid/ready lookup port evaluates one (neuron, input-code) pair per cycle. An internal FSM arbitrates between loading and lookups, and tracks which tables are valid.

Parameters:
IN_BITS, 8, width of the neuron input code (table address)
OUT_BITS, 2, width of each table entry / neuron output
NUM_NEURONS, 4, number of independent tables
NID_W, $clog2(NUM_NEURONS) (min 1), neuron index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  pulse: begin loading table cfg_neuron
cfg_neuron  in  NID_W  target neuron, sampled on accepted cfg_start
cfg_valid  in  1  table entry present
cfg_data  in  OUT_BITS  table entry, entries in address order 0..2^IN_BITS-1
cfg_ready  out  1  entry accepted when cfg_valid&&cfg_ready
cfg_busy  out  1  load in progress
req_valid  in  1  lookup request
req_neuron  in  NID_W  neuron to evaluate
req_code  in  IN_BITS  input code (M0 equivalent)
req_ready  out  1  request accepted when req_valid&&req_ready
resp_valid  out  1  result held
resp_data  out  OUT_BITS  table output (M1 equivalent)
resp_err  out  1  lookup hit an unloaded neuron or an out-of-range index
resp_ready  in  1  result consumed

Behaviour:
- Reset values: cfg_ready=0, cfg_busy=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, FSM=IDLE, loaded[]=0, load address=0. Table RAM contents are not reset.
- FSM IDLE:
  - cfg_start=1 → LOAD; latch cfg_neuron; clear loaded[cfg_neuron]; address=0.
  - cfg_start with cfg_neuron ≥ NUM_NEURONS is ignored; FSM stays IDLE.
- FSM LOAD:
  - cfg_ready=1, cfg_busy=1.
  - Each accepted entry writes RAM[neuron][address] and increments address.
  - On accepting entry 2^IN_BITS-1: set loaded[neuron], address wraps to 0, → IDLE the next cycle.
  - cfg_valid low stalls the load indefinitely.
  - cfg_start during LOAD is ignored.
- Lookups:
  - req_ready = (FSM==IDLE) && !cfg_start && (!resp_valid || resp_ready).
  - A cfg_start arriving in the same cycle as req_valid wins; the request is not accepted.
  - Latency is 1 cycle: a request accepted at edge N gives resp_valid=1 after edge N with resp_data=RAM[req_neuron][req_code].
  - If the target is unloaded or out of range: resp_data=0 and resp_err=1.
  - resp_valid/resp_data/resp_err hold until resp_ready. Back-to-back throughput is 1/cycle when resp_ready=1.
- In-flight response: a response registered before cfg_start completes normally. It is not corrupted by the following load, because the read data is registered at acceptance.
- Reset mid-load: all loaded bits are cleared; the partial table is invalid.

Decomposition:
- Package lut_neuron_pkg:
  - FSM state enum {IDLE, LOAD}
  - TABLE_DEPTH = 2**IN_BITS
  - response struct {data, err}
- One sub-module, lut_neuron_ram: 1 write port, 1 read port, registered read, (*rom_style/ram_style="distributed"*).
- The controller holds the FSM, loaded[] bits and the response register.

Test Plan:
- Reset, then lookup neuron 0 code 8'h00 → resp_valid after 1 cycle, resp_data=2'b00, resp_err=1.
- Load neuron 1 with entry[i]=i[1:0] for 256 entries, cfg_valid held high → cfg_busy high for exactly 256 cycles. Then lookup code 8'hA7 → resp_data=2'b11, resp_err=0.
- Same load with cfg_valid toggling every other cycle → 256 writes over 511 cycles. loaded[1] is set only after the last write; a final lookup of code 8'hFF returns 2'b11.
- Assert cfg_start and req_valid in the same cycle → req_ready=0 and FSM enters LOAD. A lookup of a neuron not being loaded stays stalled until the load completes.
- Hold resp_ready=0 with the result pending → req_ready=0 and resp_data stable. Then assert resp_ready with 4 queued requests → 4 responses on 4 consecutive cycles.
- Assert rst after 100 entries of a load → outputs return to reset values, loaded[neuron]=0, and a subsequent lookup gives resp_err=1.
